// File: rtl/load_store_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------------+
// | load_store_ctrl: execute-stage load/store requester for the byte-addressed data  |
// | memory. Define MISALIGN_CHECK_EN to reject size-misaligned accesses. Rev 1.0     |
// +----------------------------------------------------------------------------------+
module load_store_ctrl #(
  parameter int XLEN      = 64,
  parameter int MEM_BYTES = 2048
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_read_en,
  output logic            mem_write_en,
  output logic [2:0]      load_format,
  output logic [1:0]      store_format,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_data_input,
  input  logic [XLEN-1:0] mem_data_output
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  localparam logic [XLEN:0] LAST_BYTE = (XLEN+1)'(MEM_BYTES - 1);

  state_t      state;
  logic        acc_we;
  logic [2:0]  acc_funct3;
  logic [2:0]  size_m1;
  logic [XLEN:0] last_addr;
  logic        bad_funct3;
  logic        out_of_range;
  logic        misaligned;
  logic        reject;

  // Memory returns stale upper bytes, so mask to size before extending.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw, input logic [2:0] f3);
    logic [XLEN-1:0] ext;
    case (f3[1:0])
      2'b00:   ext = {{(XLEN-8){raw[7] & ~f3[2]}}, raw[7:0]};
      2'b01:   ext = {{(XLEN-16){raw[15] & ~f3[2]}}, raw[15:0]};
      2'b10:   ext = {{(XLEN-32){raw[31] & ~f3[2]}}, raw[31:0]};
      default: ext = raw;
    endcase
    return ext;
  endfunction

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   size_m1 = 3'd0;
      2'b01:   size_m1 = 3'd1;
      2'b10:   size_m1 = 3'd3;
      default: size_m1 = 3'd7;
    endcase
    // One extra bit so an address near the top of the space cannot wrap into range.
    last_addr    = {1'b0, req_addr} + {{(XLEN-2){1'b0}}, size_m1};
    out_of_range = last_addr > LAST_BYTE;
    bad_funct3   = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
`ifdef MISALIGN_CHECK_EN
    misaligned   = |(req_addr[2:0] & size_m1);
`else
    misaligned   = 1'b0;
`endif
    reject       = bad_funct3 | out_of_range | misaligned;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_read_en    <= 1'b0;
      mem_write_en   <= 1'b0;
      load_format    <= 3'b000;
      store_format   <= 2'b00;
      mem_addr       <= '0;
      mem_data_input <= '0;
      acc_we         <= 1'b0;
      acc_funct3     <= 3'b000;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            mem_addr       <= req_addr;
            mem_data_input <= req_wdata;
            load_format    <= (req_funct3[1:0] == 2'b11) ? 3'b101 : {1'b0, req_funct3[1:0]};
            store_format   <= req_funct3[1:0];
            acc_we         <= req_we;
            acc_funct3     <= req_funct3;
            resp_rdata     <= '0;
            req_ready      <= 1'b0;
            if (reject) begin
              state <= ST_ERROR;
            end else begin
              state        <= ST_ACCESS;
              mem_read_en  <= ~req_we;
              mem_write_en <= req_we;
            end
          end
        end
        ST_ACCESS: begin
          mem_read_en  <= 1'b0;
          mem_write_en <= 1'b0;
          state        <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          resp_valid <= 1'b1;
          resp_rdata <= acc_we ? '0 : extend(mem_data_output, acc_funct3);
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        ST_ERROR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_ctrl.sv
`default_nettype none
// Bench for load_store_ctrl: directed requests scored against a byte-array reference memory.
module tb_load_store_ctrl;
  localparam int XLEN      = 64;
  localparam int MEM_BYTES = 2048;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [2:0]      req_funct3 = 3'b000;
  logic [XLEN-1:0] req_addr = '0;
  logic [XLEN-1:0] req_wdata = '0;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            mem_read_en;
  logic            mem_write_en;
  logic [2:0]      load_format;
  logic [1:0]      store_format;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_data_input;
  logic [XLEN-1:0] mem_data_output;

  load_store_ctrl #(.XLEN(XLEN), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .load_format(load_format), .store_format(store_format),
    .mem_addr(mem_addr), .mem_data_input(mem_data_input),
    .mem_data_output(mem_data_output)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: synchronous, returns a full 8-byte window so bytes beyond the size are stale.
  logic [7:0] dmem [MEM_BYTES];
  always @(posedge clk) begin : env_mem
    longint unsigned a;
    logic [63:0] w;
    a = mem_addr;
    if (!rst_n) begin
      for (int i = 0; i < MEM_BYTES; i++) dmem[i] <= 8'h00;
    end else begin
      if (mem_write_en)
        for (int i = 0; i < (1 << store_format); i++)
          if (a + longint'(i) < MEM_BYTES) dmem[int'(a) + i] <= mem_data_input[8*i +: 8];
      if (mem_read_en) begin
        for (int i = 0; i < 8; i++)
          w[8*i +: 8] = (a + longint'(i) < MEM_BYTES) ? dmem[int'(a) + i] : 8'hAA;
        mem_data_output <= w;
      end
    end
  end

  // Reference model: what each accepted request must produce.
  logic [7:0] ref_mem [MEM_BYTES];
  typedef struct {
    logic            we;
    logic [2:0]      fmt;
    logic [XLEN-1:0] addr;
    logic            err;
    logic [XLEN-1:0] rdata;
    int              acc;
    logic            has_lit;
    logic            lit_err;
    logic [XLEN-1:0] lit_rdata;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic has_lit, input logic lit_err,
                       input logic [63:0] lit_rdata);
    exp_t e;
    int size;
    int guard;
    logic [64:0] last;
    logic [63:0] v;
    logic [2:0] lfmt [4];
    lfmt = '{3'd0, 3'd1, 3'd2, 3'd5};
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("accept_timeout", {63'd0, req_ready}, 64'd1);
      return;
    end
    size = 1 << f3[1:0];
    last = {1'b0, addr} + 65'(size - 1);
    e.err = (we ? f3[2] : (f3 == 3'b111)) || (last > 65'(MEM_BYTES - 1));
`ifdef MISALIGN_CHECK_EN
    if (addr % 64'(size) != 0) e.err = 1'b1;
`endif
    e.rdata = '0;
    if (!e.err && we) begin
      for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
    end else if (!e.err) begin
      v = '0;
      for (int i = 0; i < size; i++) v = v | (64'(ref_mem[int'(addr) + i]) << (8*i));
      if (!f3[2] && size < 8 && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 64'd1);
      e.rdata = v;
    end
    e.we = we; e.addr = addr;
    e.fmt = we ? {1'b0, f3[1:0]} : lfmt[f3[1:0]];
    e.acc = cyc + 1;
    e.has_lit = has_lit; e.lit_err = lit_err; e.lit_rdata = lit_rdata;
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic drain();
    int guard;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 64'(q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", {63'd0, resp_err}, 64'd0);
    check("rst_enables", {62'd0, mem_read_en, mem_write_en}, 64'd0);
    check("rst_formats", {59'd0, load_format, store_format}, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_data_input", mem_data_input, 64'd0);
  endtask

  // Compare process: enable pulses and responses against the head of the expectation queue.
  always @(negedge clk) begin : cmp
    exp_t e;
    int expcyc;
    if (rst_n) begin
      if (mem_read_en || mem_write_en) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL enable_unexpected rd=%b wr=%b required rd=0 wr=0", mem_read_en, mem_write_en);
        end else begin
          e = q[0];
          if (e.err || mem_read_en != !e.we || mem_write_en != e.we || mem_addr !== e.addr ||
              cyc != e.acc || req_ready !== 1'b0 ||
              (mem_write_en ? {1'b0, store_format} : load_format) !== e.fmt) begin
            miscompares++;
            $display("FAIL enable rd=%b wr=%b addr=%h cyc=%0d fmt=%0d ready=%b required rd=%b wr=%b addr=%h cyc=%0d fmt=%0d ready=0",
                     mem_read_en, mem_write_en, mem_addr, cyc,
                     mem_write_en ? {1'b0, store_format} : load_format, req_ready,
                     !e.err && !e.we, !e.err && e.we, e.addr, e.acc, e.fmt);
          end
        end
      end
      if (resp_valid) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL resp_unexpected err=%b rdata=%h required no response", resp_err, resp_rdata);
        end else begin
          e = q.pop_front();
          expcyc = e.acc + (e.err ? 1 : 2);
          if (resp_err !== e.err || resp_rdata !== e.rdata || cyc != expcyc || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL resp err=%b rdata=%h cyc=%0d ready=%b required err=%b rdata=%h cyc=%0d ready=1",
                     resp_err, resp_rdata, cyc, req_ready, e.err, e.rdata, expcyc);
          end
          if (e.has_lit) begin
            vectors++;
            if (resp_err !== e.lit_err || resp_rdata !== e.lit_rdata) begin
              miscompares++;
              $display("FAIL resp_literal err=%b rdata=%h required err=%b rdata=%h",
                       resp_err, resp_rdata, e.lit_err, e.lit_rdata);
            end
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs();
    rst_n = 1'b1;

    issue(1, 3'b011, 64'h10, 64'h8877665544332211, 1, 0, 64'h0);
    issue(0, 3'b011, 64'h10, 64'h0, 1, 0, 64'h8877665544332211);
    issue(0, 3'b000, 64'h10, 64'h0, 1, 0, 64'h11);
    issue(0, 3'b001, 64'h16, 64'h0, 1, 0, 64'hFFFFFFFFFFFF8877);
    issue(0, 3'b101, 64'h16, 64'h0, 1, 0, 64'h8877);
    drain();

    issue(1, 3'b000, 64'h20, 64'h123456789ABCDEFF, 1, 0, 64'h0);
    issue(0, 3'b000, 64'h20, 64'h0, 1, 0, 64'hFFFFFFFFFFFFFFFF);
    issue(0, 3'b100, 64'h20, 64'h0, 1, 0, 64'h00000000000000FF);
    issue(1, 3'b011, 64'h40, 64'hFFFFFFFFFFFFFFFF, 1, 0, 64'h0);
    issue(1, 3'b010, 64'h40, 64'h0000000080000001, 1, 0, 64'h0);
    issue(0, 3'b010, 64'h40, 64'h0, 1, 0, 64'hFFFFFFFF80000001);
    issue(0, 3'b110, 64'h40, 64'h0, 1, 0, 64'h0000000080000001);
    issue(0, 3'b011, 64'h40, 64'h0, 1, 0, 64'hFFFFFFFF80000001);
    drain();

    // Range and funct3 rejections.
    issue(0, 3'b011, 64'd2044, 64'h0, 1, 1, 64'h0);
    issue(0, 3'b011, 64'd2040, 64'h0, 1, 0, 64'h0);
    issue(0, 3'b000, 64'd2047, 64'h0, 1, 0, 64'h0);
    issue(1, 3'b001, 64'd2047, 64'h5A5A, 1, 1, 64'h0);
    issue(0, 3'b011, 64'hFFFFFFFFFFFFFFF9, 64'h0, 1, 1, 64'h0);
    issue(0, 3'b111, 64'h10, 64'h0, 1, 1, 64'h0);
    issue(1, 3'b100, 64'h10, 64'hDEAD, 1, 1, 64'h0);
    issue(0, 3'b011, 64'h10, 64'h0, 1, 0, 64'h8877665544332211);
    drain();

    issue(1, 3'b001, 64'h22, 64'hA5C3, 1, 0, 64'h0);
`ifdef MISALIGN_CHECK_EN
    issue(0, 3'b001, 64'h21, 64'h0, 1, 1, 64'h0);
`else
    issue(0, 3'b001, 64'h21, 64'h0, 1, 0, 64'hFFFFFFFFFFFFC300);
`endif
    issue(0, 3'b010, 64'h41, 64'h0, 0, 0, 64'h0);
    issue(1, 3'b011, 64'h44, 64'h0102030405060708, 0, 0, 64'h0);
    issue(0, 3'b011, 64'h40, 64'h0, 0, 0, 64'h0);
    drain();

    // Reset while the load is in its access cycle: no response, outputs back to reset values.
    issue(0, 3'b011, 64'h10, 64'h0, 1, 0, 64'h8877665544332211);
    @(negedge clk); #1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    q.delete();
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    issue(1, 3'b011, 64'h8, 64'hCAFEBABE12345678, 1, 0, 64'h0);
    issue(0, 3'b011, 64'h10, 64'h0, 1, 0, 64'h0);
    issue(0, 3'b010, 64'h8, 64'h0, 1, 0, 64'h0000000012345678);
    issue(0, 3'b001, 64'hC, 64'h0, 1, 0, 64'hFFFFFFFFFFFFBABE);
    issue(0, 3'b000, 64'hF, 64'h0, 1, 0, 64'hFFFFFFFFFFFFFFCA);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
